// File: rtl/uart_pkg.sv
// Shared UART timing constants and divisor helpers, used by the baud generator and the RX/TX engines.
package uart_pkg;

    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 163;
    localparam int OVS         = 16;
    localparam int FRAC_W      = 4;
    localparam int PH_W        = $clog2(OVS);

    typedef logic [DIV_W-1:0]  div_t;
    typedef logic [FRAC_W-1:0] frac_t;
    typedef logic [PH_W-1:0]   phase_t;

    // A zero divisor would never reach terminal count, so it is treated as 1.
    function automatic div_t clamp_div(input div_t d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/baud_div_core.sv
// Oversample divider: counter, pending/active divisor and registered tick_ovs.
// Define BAUD_FRAC_EN to build the fractional accumulator that stretches selected periods by one clock.
module baud_div_core
    import uart_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  clr,
    input  logic  div_wr,
    input  div_t  div_in,
    input  frac_t frac_in,
    output logic  wrap,
    output logic  tick_ovs,
    output div_t  div_cur
);

    div_t          cnt;
    div_t          div_act;
    div_t          div_pend;
    logic          pend_vld;
    div_t          div_new;
    div_t          div_nxt;
    logic          extra;
    logic [DIV_W:0] term;

`ifdef BAUD_FRAC_EN
    frac_t         frac_act;
    frac_t         frac_pend;
    frac_t         frac_nxt;
    frac_t         acc;
    logic [FRAC_W:0] acc_sum;

    // The period whose wrap carries the accumulator is the one that gets the extra clock.
    assign acc_sum = {1'b0, acc} + {1'b0, frac_act};
    assign extra   = acc_sum[FRAC_W];

    always_comb begin
        frac_nxt = frac_act;
        if (div_wr) begin
            frac_nxt = frac_in;
        end else if (pend_vld) begin
            frac_nxt = frac_pend;
        end
    end
`else
    logic unused_frac;

    assign unused_frac = ^frac_in;
    assign extra       = 1'b0;
`endif

    assign div_new = clamp_div(div_in);
    assign term    = {1'b0, div_act} - (DIV_W+1)'(1) + {{DIV_W{1'b0}}, extra};
    assign wrap    = en && !clr && ({1'b0, cnt} == term);
    assign div_cur = div_act;

    // A write landing on the wrap cycle governs the period that starts there.
    always_comb begin
        div_nxt = div_act;
        if (div_wr) begin
            div_nxt = div_new;
        end else if (pend_vld) begin
            div_nxt = div_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            div_act   <= DIV_W'(DEFAULT_DIV);
            div_pend  <= '0;
            pend_vld  <= 1'b0;
            tick_ovs  <= 1'b0;
`ifdef BAUD_FRAC_EN
            frac_act  <= '0;
            frac_pend <= '0;
            acc       <= '0;
`endif
        end else if (clr) begin
            cnt      <= '0;
            tick_ovs <= 1'b0;
`ifdef BAUD_FRAC_EN
            acc      <= '0;
`endif
        end else begin
            tick_ovs <= wrap;
            if (!en) begin
                if (div_wr) begin
                    div_act  <= div_new;
                    cnt      <= '0;
                    pend_vld <= 1'b0;
`ifdef BAUD_FRAC_EN
                    frac_act <= frac_in;
`endif
                end
            end else if (wrap) begin
                cnt      <= '0;
                div_act  <= div_nxt;
                pend_vld <= 1'b0;
`ifdef BAUD_FRAC_EN
                frac_act <= frac_nxt;
                acc      <= acc_sum[FRAC_W-1:0];
`endif
            end else begin
                cnt <= cnt + DIV_W'(1);
                if (div_wr) begin
                    div_pend <= div_new;
                    pend_vld <= 1'b1;
`ifdef BAUD_FRAC_EN
                    frac_pend <= frac_in;
`endif
                end
            end
        end
    end

endmodule

// File: rtl/baud_gen_prog.sv
// Programmable UART baud generator: oversample strobe from baud_div_core plus phase index and bit strobe.
// Fractional divisor support is built only when BAUD_FRAC_EN is defined.
module baud_gen_prog
    import uart_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   div_wr,
    input  div_t   div_in,
    input  frac_t  frac_in,
    input  logic   clr_phase,
    output logic   tick_ovs,
    output logic   tick_bit,
    output phase_t phase,
    output div_t   div_cur
);

    logic wrap;

    baud_div_core u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr_phase),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .frac_in  (frac_in),
        .wrap     (wrap),
        .tick_ovs (tick_ovs),
        .div_cur  (div_cur)
    );

    // OVS is a power of two, so the phase counter wraps on its own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase    <= '0;
            tick_bit <= 1'b0;
        end else if (clr_phase) begin
            phase    <= '0;
            tick_bit <= 1'b0;
        end else begin
            tick_bit <= wrap && (phase == PH_W'(OVS - 1));
            if (wrap) begin
                phase <= phase + PH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_prog.sv
// Directed bench for baud_gen_prog: divisor load/change, enable hold, phase clear, fractional mode, clamp and reset.
module tb_baud_gen_prog;
    import uart_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   en = 1'b0;
    logic   div_wr = 1'b0;
    div_t   div_in = '0;
    frac_t  frac_in = '0;
    logic   clr_phase = 1'b0;
    logic   tick_ovs;
    logic   tick_bit;
    phase_t phase;
    div_t   div_cur;

    int n_chk = 0;
    int n_pass = 0;

    baud_gen_prog dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_wr    (div_wr),
        .div_in    (div_in),
        .frac_in   (frac_in),
        .clr_phase (clr_phase),
        .tick_ovs  (tick_ovs),
        .tick_bit  (tick_bit),
        .phase     (phase),
        .div_cur   (div_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until tick_ovs is seen, counted from the current cycle.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_ovs && n < 400);
        if (!tick_ovs) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int sum;
        int bit_at;

        // 1: reset, load div 4, 16 ticks of 4 clocks, tick_bit on the 16th
        step();
        chk("rst_tick_ovs", tick_ovs, 0);
        chk("rst_tick_bit", tick_bit, 0);
        chk("rst_phase", phase, 0);
        chk("rst_div_cur", div_cur, 163);
        rst_n = 1'b1;
        div_wr = 1'b1; div_in = 16'd4;
        step();
        div_wr = 1'b0;
        chk("load_idle_div", div_cur, 4);
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wait_tick(n);
            chk("t1_period", n, 4);
            chk("t1_phase", phase, i % 16);
            chk("t1_tick_bit", tick_bit, (i == 16) ? 1 : 0);
        end

        // 2: write 10 at cnt=1; current period still ends at 4 clocks
        step();
        div_wr = 1'b1; div_in = 16'd10;
        step();
        div_wr = 1'b0;
        wait_tick(n);
        chk("t2_old_period_rest", n, 2);
        chk("t2_div_applied", div_cur, 10);
        wait_tick(n);
        chk("t2_new_period_a", n, 10);
        wait_tick(n);
        chk("t2_new_period_b", n, 10);
        chk("t2_phase", phase, 3);

        // 3: hold at cnt=2 for 7 cycles, then 8 clocks remain of the 10
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t3_no_ovs", tick_ovs, 0);
            chk("t3_no_bit", tick_bit, 0);
            chk("t3_phase_hold", phase, 3);
        end
        en = 1'b1;
        wait_tick(n);
        chk("t3_resume", n, 8);
        chk("t3_phase_adv", phase, 4);

        // 4: back to div 4, run to phase 9, then clear the phase
        div_wr = 1'b1; div_in = 16'd4;
        step();
        div_wr = 1'b0;
        wait_tick(n);
        chk("t4_old_period", n, 9);
        chk("t4_div_cur", div_cur, 4);
        for (int i = 0; i < 4; i++) wait_tick(n);
        chk("t4_phase_before", phase, 9);
        step();
        clr_phase = 1'b1;
        step();
        clr_phase = 1'b0;
        chk("t4_clr_phase", phase, 0);
        chk("t4_clr_no_tick", tick_ovs, 0);
        wait_tick(n);
        chk("t4_first_after_clr", n, 4);
        bit_at = tick_bit ? 1 : 0;
        for (int i = 2; i <= 16; i++) begin
            wait_tick(n);
            if (tick_bit && bit_at == 0) bit_at = i;
        end
        chk("t4_bit_index", bit_at, 16);

        // 5: div 4 frac 8; fractional build stretches every other period
        en = 1'b0;
        clr_phase = 1'b1;
        step();
        clr_phase = 1'b0;
        div_wr = 1'b1; div_in = 16'd4; frac_in = 4'd8;
        step();
        div_wr = 1'b0; frac_in = '0;
        en = 1'b1;
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            wait_tick(n);
            sum += n;
        end
`ifdef BAUD_FRAC_EN
        chk("t5_16_ticks_cycles", sum, 72);
`else
        chk("t5_16_ticks_cycles", sum, 64);
`endif
        chk("t5_tick_bit", tick_bit, 1);

        // 6: div_in 0 clamps to 1, then reset mid-run
        en = 1'b0;
        div_wr = 1'b1; div_in = 16'd0;
        step();
        div_wr = 1'b0;
        chk("t6_clamp", div_cur, 1);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_every_cycle", tick_ovs, 1);
        end
        rst_n = 1'b0;
        step();
        chk("t6_rst_tick_ovs", tick_ovs, 0);
        chk("t6_rst_tick_bit", tick_bit, 0);
        chk("t6_rst_phase", phase, 0);
        chk("t6_rst_div_cur", div_cur, 163);
        rst_n = 1'b1;
        en = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
